// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the sequential restoring divider.
//   - state_t       : controller states (IDLE, CALC, FIX)
//   - DEFAULT_WIDTH : default operand/result width in bits
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_sub_nbit.sv
// -----------------------------------------------------------------------------
// sub_nbit
//   Combinational WIDTH-bit subtractor used for the divider's trial subtract.
//   The difference is formed as a + ~b + 1; a borrow is the absence of a
//   carry out of the top bit.
//
// Ports
//   a      in   WIDTH  minuend
//   b      in   WIDTH  subtrahend
//   diff   out  WIDTH  a - b (modulo 2^WIDTH)
//   borrow out  1      1 when b > a (unsigned)
// -----------------------------------------------------------------------------
module sub_nbit #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] sum_ext;

  assign sum_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign diff    = sum_ext[WIDTH-1:0];
  assign borrow  = ~sum_ext[WIDTH];

endmodule : sub_nbit

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider, one quotient bit per clock, supporting
//   signed (DIV) and unsigned (DIVU) operation. Operands are reduced to
//   magnitudes on acceptance, divided unsigned over WIDTH CALC cycles, and
//   sign-corrected in a single FIX cycle.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request pulse, honoured only while idle
//   is_signed    in   1      1 = two's-complement divide, 0 = unsigned
//   dividend     in   WIDTH  numerator, captured with start
//   divisor      in   WIDTH  denominator, captured with start
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  LO result, held until next completion
//   remainder    out  WIDTH  HI result, held until next completion
//   div_by_zero  out  1      divisor was zero in the last operation
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  // Two's-complement negation on an explicitly signed value.
  function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
    return -v;
  endfunction

  // Magnitude of an operand: absolute value in signed mode, raw otherwise.
  // The most-negative value maps to itself, which is its correct unsigned
  // magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (sgn && sv[WIDTH-1]) return negate(sv);
    return v;
  endfunction

  state_t             state_q, state_d;
  logic               accept, fix;

  logic [WIDTH-1:0]   quo_q;       // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH:0]     rem_q;       // partial remainder
  logic [WIDTH-1:0]   dvs_mag_q;
  logic [WIDTH-1:0]   dvd_raw_q;   // original dividend, returned as remainder on divide-by-zero
  logic               neg_dvd_q, neg_dvs_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   quotient_q, remainder_q;
  logic               done_q, dbz_q;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial_diff;
  logic               trial_borrow;

  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               dbz_fix;

  // ---------------------------------------------------------------------------
  // Trial subtraction: shift next dividend bit into the partial remainder
  // ---------------------------------------------------------------------------
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  sub_nbit #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_mag_q}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // ---------------------------------------------------------------------------
  // Controller: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fix     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Sign correction and divide-by-zero override for the FIX cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    quo_fix = (neg_dvd_q ^ neg_dvs_q) ? negate(quo_q) : quo_q;
    rem_fix = neg_dvd_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
    dbz_fix = 1'b0;
    // The raw iteration already yields all-ones for a zero divisor, but the
    // sign fix would disturb it, so both results are forced here.
    if (dvs_mag_q == '0) begin
      quo_fix = '1;
      rem_fix = dvd_raw_q;
      dbz_fix = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture on accept, one restoring step per CALC cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_mag_q <= '0;
      dvd_raw_q <= '0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      quo_q     <= magnitude(dividend, is_signed);
      dvs_mag_q <= magnitude(divisor, is_signed);
      dvd_raw_q <= dividend;
      neg_dvd_q <= is_signed & dividend[WIDTH-1];
      neg_dvs_q <= is_signed & divisor[WIDTH-1];
      rem_q     <= '0;
      cnt_q     <= '0;
    end else if (state_q == ST_CALC) begin
      if (trial_borrow) begin
        rem_q <= shifted;
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= trial_diff;
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers and completion pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= fix;
      if (fix) begin
        quotient_q  <= quo_fix;
        remainder_q <= rem_fix;
        dbz_q       <= dbz_fix;
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed self-checking bench for seq_divider (WIDTH = 32) with
//   hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Present operands and hold start across exactly one rising edge (E0).
  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  // Count edges after E0 until done is seen; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] eq,
                     input logic [W-1:0] er, input logic ef);
    int n;
    start_op(sgn, a, b);
    chk({tag, "_busy"}, W'(busy), W'(1));
    wait_done(n);
    chk({tag, "_lat"}, W'(n), W'(33));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, W'(div_by_zero), W'(ef));
  endtask

  initial begin
    int n, dc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    chk("rst_dbz", W'(div_by_zero), '0);
    @(negedge clk);
    rst = 1'b0;

    // Main function
    run("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run("s-7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run("s7_-2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
    run("s-7_-2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0);
    run("uFFFF_2",   1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0);
    run("uFFFF_2s",  1'b1, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFF,  1'b0);

    // Divide by zero and most-negative / -1
    run("u5_0",      1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1);
    run("s5_0",      1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1);
    run("s-5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
    run("smin_-1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);

    // start while busy is ignored
    start_op(1'b0, 32'd100, 32'd7);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (n == 5) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
      end else if (n == 6) begin
        start = 1'b0;
      end
    end
    chk("ign_lat", W'(n), W'(33));
    chk("ign_q", quotient, 32'd14);
    chk("ign_r", remainder, 32'd2);

    // start in the done cycle is accepted
    start_op(1'b0, 32'd50, 32'd6);
    wait_done(n);
    start_op(1'b0, 32'd77, 32'd10);
    wait_done(n);
    chk("b2b_lat", W'(n), W'(33));
    chk("b2b_q", quotient, 32'd7);
    chk("b2b_r", remainder, 32'd7);

    // Reset mid-operation
    start_op(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_busy", W'(busy), '0);
    chk("mid_done", W'(done), '0);
    chk("mid_q", quotient, '0);
    chk("mid_r", remainder, '0);
    chk("mid_dbz", W'(div_by_zero), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    chk("mid_nodone", W'(dc), '0);
    run("post_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement divide (MIPS DIV), 0 = unsigned divide (DIVU); captured with start.
REQ-006 dividend  input  WIDTH  numerator; captured with start.
REQ-007 divisor  input  WIDTH  denominator; captured with start.
REQ-008 busy  output  1  high from the edge after start acceptance until done asserts.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 quotient  output  WIDTH  LO result, held until next accepted start.
REQ-011 remainder  output  WIDTH  HI result, held until next accepted start.
REQ-012 div_by_zero  output  1  flag for the last completed operation, held with results.

Function
REQ-013 States SHALL be IDLE, CALC, FIX; IDLE->CALC on start; CALC->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-014 On acceptance edge (E0) the block SHALL register operand magnitudes (absolute values when is_signed, raw otherwise), both sign bits, clear the partial remainder (WIDTH+1 bits) and iteration counter.
REQ-015 Each CALC edge SHALL shift the partial remainder left, shift in the next dividend MSB, trial-subtract the divisor magnitude, keep the difference and shift in quotient bit 1 if no borrow, otherwise keep the shifted value and shift in 0 (restoring algorithm, one bit per cycle).
REQ-016 Trial subtraction SHALL be computed as a + ~b + 1; borrow = NOT carry-out.
REQ-017 The FIX edge SHALL negate the quotient if signs differ and negate the remainder if dividend was negative (signed mode only), register results, and set done for one cycle.
REQ-018 Latency: done SHALL be high in the cycle following edge E(WIDTH+1), i.e. 33 edges after acceptance for WIDTH=32.
REQ-019 start while busy SHALL be ignored with no effect on the running operation.
REQ-020 start in the done cycle SHALL be accepted (state is IDLE).
REQ-021 Divisor zero: SHALL run full latency, then quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1.
REQ-022 Signed most-negative / -1 SHALL yield quotient = most-negative value, remainder = 0, no flag.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder (mod 2^WIDTH) with |remainder| < |divisor| for every non-zero divisor.

Reset
REQ-024 rst SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers to 0 immediately, independent of clk.
REQ-025 Reset mid-operation SHALL abandon the operation; no done pulse SHALL follow.

Structure
REQ-026 A shared package SHALL hold the state enumeration and the default WIDTH constant.
REQ-027 One sub-module, sub_nbit (combinational WIDTH+1-bit subtractor with borrow-out), SHALL be instantiated once for the trial subtraction.

Verification
REQ-028 Unsigned 100/7 -> done after 33 edges, quotient 14, remainder 2, flag 0.
REQ-029 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFFF/2 -> quotient 0x7FFFFFFF, remainder 1.
REQ-030 5/0 (either mode) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, flag 0.
REQ-032 Reset asserted 10 cycles into an operation -> busy 0 and all outputs 0 at once, no done; new start afterwards completes normally.
REQ-033 start pulsed mid-operation with new operands -> original results unchanged; start in done cycle -> second result 33 edges later.
